// File: rtl/intro_sprite_fetch_pkg.sv
// Shared definitions for the intro-screen sprite fetch: image geometry,
// fade FSM states, fade range and the 4x4 ordered-dither matrix.
package intro_pkg;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int ADDR_W    = 17;
    localparam int LEVEL_MAX = 16;

    typedef enum logic [2:0] {
        IDLE,
        FADE_IN,
        SHOW,
        FADE_OUT,
        DONE
    } fade_state_t;

    // Standard 4x4 Bayer matrix, row-major, indexed by {y[1:0], x[1:0]}.
    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    // Intro image contents: the palette index stored at each address.
    // The current artwork is a test card whose index is the low nibble
    // of the pixel address.
    function automatic logic [3:0] image_word(input logic [ADDR_W-1:0] addr);
        return addr[3:0];
    endfunction

endpackage

// File: rtl/intro_sprite_fetch_rom.sv
// 76800 x 4-bit intro image ROM with one cycle of read latency.
module intro_rom
    import intro_pkg::*;
(
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        data
);

    // Registered read of the image word at addr.
    always_ff @(posedge Clk) begin
        data <= image_word(addr);
    end

endmodule

// File: rtl/intro_sprite_fetch.sv
// Intro-screen sprite fetch: maps draw coordinates to a palette index
// from the intro ROM (2x scaled), keeps blank aligned with the index and
// applies a frame-timed fade in/out by forcing index 0 on a pixel subset.
// Optional macro INTRO_DITHER_EN selects a 4x4 Bayer threshold; without it
// the threshold is fixed at 8, giving a hard cut at level 9.
module intro_sprite_fetch
    import intro_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int FADE_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    input  logic       vsync,
    input  logic       start,
    input  logic       skip,
    output logic [3:0] index,
    output logic       blank_q,
    output logic [4:0] level,
    output logic       done
);

    logic [8:0]        x_half;
    logic [8:0]        y_half;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              inrange_d;
    logic              inrange_p1_q;
    logic              inrange_p2_q;
    logic              blank_p1_q;
    logic              blank_p2_q;
    logic [3:0]        dlo_p1_q;
    logic [3:0]        dlo_p2_q;
    logic [3:0]        rom_data;
    logic [3:0]        threshold;

    fade_state_t       state_q;
    fade_state_t       state_d;
    logic [4:0]        level_q;
    logic [4:0]        level_d;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic              vsync_q;
    logic              tick;
    logic              step;

    assign x_half    = DrawX[9:1];
    assign y_half    = DrawY[9:1];
    assign addr_d    = ADDR_W'(y_half) * ADDR_W'(IMG_W) + ADDR_W'(x_half);
    assign inrange_d = (32'(x_half) < IMG_W) && (32'(y_half) < IMG_H);

    // Two-stage coordinate pipeline: stage 1 holds the address, stage 2
    // lines up with the ROM output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            addr_q       <= '0;
            inrange_p1_q <= 1'b0;
            blank_p1_q   <= 1'b0;
            dlo_p1_q     <= '0;
            inrange_p2_q <= 1'b0;
            blank_p2_q   <= 1'b0;
            dlo_p2_q     <= '0;
        end else begin
            addr_q       <= addr_d;
            inrange_p1_q <= inrange_d;
            blank_p1_q   <= blank;
            dlo_p1_q     <= {DrawY[1:0], DrawX[1:0]};
            inrange_p2_q <= inrange_p1_q;
            blank_p2_q   <= blank_p1_q;
            dlo_p2_q     <= dlo_p1_q;
        end
    end

    intro_rom u_rom (
        .Clk  (Clk),
        .addr (addr_q),
        .data (rom_data)
    );

`ifdef INTRO_DITHER_EN
    assign threshold = BAYER[dlo_p2_q];
`else
    logic unused_dither;
    assign threshold     = 4'd8;
    assign unused_dither = ^dlo_p2_q;
`endif

    assign index   = (inrange_p2_q && ({1'b0, threshold} < level_q)) ? rom_data : 4'd0;
    assign blank_q = blank_p2_q;
    assign level   = level_q;
    assign done    = (state_q == DONE);
    assign tick    = vsync_q & ~vsync;

    // Fade state, level, frame counter and vsync edge history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            level_q <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            vsync_q <= vsync;
        end
    end

    // Next-state logic: frame counting, level stepping and transitions.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        step    = 1'b0;

        if ((state_q == FADE_IN || state_q == FADE_OUT) && tick) begin
            if (cnt_q >= 8'(FADE_FRAMES - 1)) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                level_d = '0;
                if (start) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (skip) begin
                    state_d = FADE_OUT;
                end else if (step) begin
                    if (level_q >= 5'(LEVEL_MAX - 1)) begin
                        level_d = 5'(LEVEL_MAX);
                        state_d = SHOW;
                    end else begin
                        level_d = level_q + 5'd1;
                    end
                end
            end
            SHOW: begin
                level_d = 5'(LEVEL_MAX);
                if (skip) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (step) begin
                    if (level_q <= 5'd1) begin
                        level_d = '0;
                        state_d = DONE;
                    end else begin
                        level_d = level_q - 5'd1;
                    end
                end
            end
            DONE: begin
                level_d = '0;
                if (start) state_d = FADE_IN;
            end
            default: begin
                state_d = IDLE;
                level_d = '0;
            end
        endcase

        // A new state always starts a fresh frame count.
        if (state_d != state_q) cnt_d = '0;
    end

endmodule

// File: tb/tb_intro_sprite_fetch.sv
// Directed bench for intro_sprite_fetch (default image geometry plus a
// second instance with a 200-line image for the vertical bound).
module tb_intro_sprite_fetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       vsync;
    logic       start;
    logic       skip;
    logic [3:0] index;
    logic       blank_q;
    logic [4:0] level;
    logic       done;
    logic [3:0] index2;
    logic       blank_q2;
    logic [4:0] level2;
    logic       done2;

    int total = 0;
    int bad   = 0;

`ifdef INTRO_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    always #5 Clk = ~Clk;

    intro_sprite_fetch #(.IMG_W(320), .IMG_H(240), .FADE_FRAMES(4)) dut (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .vsync(vsync), .start(start), .skip(skip), .index(index),
        .blank_q(blank_q), .level(level), .done(done)
    );

    intro_sprite_fetch #(.IMG_W(320), .IMG_H(200), .FADE_FRAMES(4)) dut2 (
        .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .vsync(vsync), .start(start), .skip(skip), .index(index2),
        .blank_q(blank_q2), .level(level2), .done(done2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            vsync = 1'b0;
            repeat (2) cycle();
            vsync = 1'b1;
            repeat (2) cycle();
        end
    endtask

    task automatic pixel(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        repeat (2) cycle();
    endtask

    logic [7:0] bpat;

    initial begin
        Reset = 1'b1;
        DrawX = '0;
        DrawY = '0;
        blank = 1'b0;
        vsync = 1'b1;
        start = 1'b0;
        skip  = 1'b0;
        bpat  = 8'b0110_1101;
        repeat (3) cycle();
        check("rst_index", int'(index), 0);
        check("rst_blank_q", int'(blank_q), 0);
        check("rst_level", int'(level), 0);
        check("rst_done", int'(done), 0);
        Reset = 1'b0;
        cycle();

        // start and skip together in IDLE: start wins
        start = 1'b1; skip = 1'b1;
        cycle();
        start = 1'b0; skip = 1'b0;
        check("ss_level0", int'(level), 0);
        check("ss_done0", int'(done), 0);
        ticks(3);
        check("ss_level_3ticks", int'(level), 0);
        ticks(1);
        check("ss_level_first_step", int'(level), 1);

        // level 5: pixel (5,1) has Bayer 4, pixel (7,3) has Bayer 5
        ticks(16);
        check("lvl5", int'(level), 5);
        pixel(5, 1);
        check("lvl5_bayer4", int'(index), DITHER ? 2 : 0);
        pixel(7, 3);
        check("lvl5_bayer5", int'(index), 0);
        ticks(12);
        check("lvl8", int'(level), 8);
        pixel(5, 1);
        check("lvl8_pix", int'(index), DITHER ? 2 : 0);
        ticks(4);
        check("lvl9", int'(level), 9);
        check("lvl9_pix", int'(index), 2);

        // skip at level 10 during fade-in
        ticks(4);
        check("lvl10", int'(level), 10);
        skip = 1'b1;
        cycle();
        skip = 1'b0;
        check("skip_keep_level", int'(level), 10);
        ticks(4);
        check("fo_lvl9", int'(level), 9);
        ticks(32);
        check("fo_lvl1", int'(level), 1);
        check("fo_not_done", int'(done), 0);
        ticks(4);
        check("fo_lvl0", int'(level), 0);
        check("fo_done", int'(done), 1);

        // restart from DONE, full fade-in to SHOW
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("restart_done_low", int'(done), 0);
        ticks(64);
        check("show_lvl16", int'(level), 16);
        check("show_lvl16_b", int'(level2), 16);
        start = 1'b1;
        cycle();
        start = 1'b0;
        ticks(4);
        check("show_ignores_start", int'(level), 16);

        // streaming sweep: index and blank_q exactly two cycles late
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                DrawX = 10'(i);
                DrawY = '0;
                blank = bpat[3'(i)];
            end
            @(negedge Clk);
            if (i >= 2) begin
                check("sweep_index", int'(index), (i - 2) >> 1);
                check("sweep_blank_q", int'(blank_q), int'(bpat[3'(i - 2)]));
            end
            cycle();
        end

        // address bounds
        blank = 1'b1;
        pixel(639, 479);
        check("corner_index", int'(index), 15);
        check("corner_addr", int'(dut.addr_q), 76799);
        check("corner_h200", int'(index2), 0);
        check("corner_blank_h200", int'(blank_q2), 1);
        pixel(2, 400);
        check("y400_index", int'(index), 1);
        check("y400_h200", int'(index2), 0);
        pixel(2, 480);
        check("y480_index", int'(index), 0);

        // fade out to level 7, then reset mid-fade
        skip = 1'b1;
        cycle();
        skip = 1'b0;
        ticks(36);
        check("fo2_lvl7", int'(level), 7);
        pixel(2, 0);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_level", int'(level), 0);
        check("midrst_index", int'(index), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_done_h200", int'(done2), 0);
        cycle();
        Reset = 1'b0;
        ticks(8);
        check("postrst_level", int'(level), 0);
        check("postrst_done", int'(done), 0);
        pixel(2, 0);
        check("postrst_index", int'(index), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
